alu_issue_unit: RTL and testbench

Initiator-side front end for the `ALU` block. It buffers operation requests from the sequencer in a request FIFO and drives the ALU's `op`/`floating`/`form`/`precision`/`A`–`D` inputs from registers. It captures `Y1`/`Y2` after a fixed ALU latency and returns tagged results in order over a valid/ready response port. A credit counter guarantees that every issued operation has a guaranteed result slot, so no result is ever dropped.

---
 rtl/alu_issue_unit.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: request FIFO -> registered ALU issue -> tag pipeline -> result FIFO.
// Credits bound in-flight ops to result-FIFO space, so a capture can never overflow.
module alu_issue_unit #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 0,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_floating,
  input  logic             req_form,
  input  logic [1:0]       req_precision,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [31:0]      req_c,
  input  logic [31:0]      req_d,
  input  logic [TAG_W-1:0] req_tag,
  output logic             alu_valid,
  output logic [2:0]       alu_op,
  output logic             alu_floating,
  output logic             alu_form,
  output logic [1:0]       alu_precision,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [31:0]      alu_c,
  output logic [31:0]      alu_d,
  input  logic [31:0]      alu_y1,
  input  logic [31:0]      alu_y2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y1,
  output logic [31:0]      rsp_y2,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]       op;
    logic             floating;
    logic             form;
    logic [1:0]       precision;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      c;
    logic [31:0]      d;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [31:0]      y1;
    logic [31:0]      y2;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  req_t             r_req_mem [DEPTH];
  rsp_t             r_rsp_mem [DEPTH];
  logic [PW-1:0]    r_req_wr, r_req_rd;
  logic [PW-1:0]    r_rsp_wr, r_rsp_rd;
  logic [CW-1:0]    r_credits;
  logic [ALU_LAT:0] r_tp_vld;
  logic [TAG_W-1:0] r_tp_tag [ALU_LAT+1];

  logic             r_alu_valid;
  logic [2:0]       r_alu_op;
  logic             r_alu_floating;
  logic             r_alu_form;
  logic [1:0]       r_alu_precision;
  logic [31:0]      r_alu_a, r_alu_b, r_alu_c, r_alu_d;

  logic w_req_full, w_req_empty, w_rsp_empty;
  logic w_accept, w_issue, w_capture, w_pop;
  req_t w_req_in, w_req_head;
  rsp_t w_rsp_in, w_rsp_head;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign w_req_full  = (r_req_wr[AW] != r_req_rd[AW]) && (r_req_wr[AW-1:0] == r_req_rd[AW-1:0]);
  assign w_req_empty = (r_req_wr == r_req_rd);
  assign w_rsp_empty = (r_rsp_wr == r_rsp_rd);

  assign w_accept  = req_valid && !w_req_full;
  assign w_issue   = !w_req_empty && (r_credits != '0);
  assign w_capture = r_tp_vld[ALU_LAT];
  assign w_pop     = !w_rsp_empty && rsp_ready;

  assign w_req_in = '{op: req_op, floating: req_floating, form: req_form,
                      precision: req_precision, a: req_a, b: req_b, c: req_c,
                      d: req_d, tag: req_tag};
  assign w_rsp_in   = '{y1: alu_y1, y2: alu_y2, tag: r_tp_tag[ALU_LAT]};
  assign w_req_head = r_req_mem[r_req_rd[AW-1:0]];
  assign w_rsp_head = r_rsp_mem[r_rsp_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_accept) r_req_mem[r_req_wr[AW-1:0]] <= w_req_in;
    if (w_capture) r_rsp_mem[r_rsp_wr[AW-1:0]] <= w_rsp_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_wr  <= '0;
      r_req_rd  <= '0;
      r_rsp_wr  <= '0;
      r_rsp_rd  <= '0;
      r_credits <= CW'(DEPTH);
    end else begin
      if (w_accept)  r_req_wr <= r_req_wr + PW'(1);
      if (w_issue)   r_req_rd <= r_req_rd + PW'(1);
      if (w_capture) r_rsp_wr <= r_rsp_wr + PW'(1);
      if (w_pop)     r_rsp_rd <= r_rsp_rd + PW'(1);
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Operand/control registers hold their last value between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_valid     <= 1'b0;
      r_alu_op        <= '0;
      r_alu_floating  <= 1'b0;
      r_alu_form      <= 1'b0;
      r_alu_precision <= '0;
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_alu_c         <= '0;
      r_alu_d         <= '0;
    end else begin
      r_alu_valid <= w_issue;
      if (w_issue) begin
        r_alu_op        <= w_req_head.op;
        r_alu_floating  <= w_req_head.floating;
        r_alu_form      <= w_req_head.form;
        r_alu_precision <= w_req_head.precision;
        r_alu_a         <= w_req_head.a;
        r_alu_b         <= w_req_head.b;
        r_alu_c         <= w_req_head.c;
        r_alu_d         <= w_req_head.d;
      end
    end
  end

  // Tag pipeline: stage 0 aligns with alu_valid, stage ALU_LAT with valid Y1/Y2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tp_vld <= '0;
      for (int i = 0; i <= ALU_LAT; i++) r_tp_tag[i] <= '0;
    end else begin
      r_tp_vld[0] <= w_issue;
      r_tp_tag[0] <= w_req_head.tag;
      for (int i = 1; i <= ALU_LAT; i++) begin
        r_tp_vld[i] <= r_tp_vld[i-1];
        r_tp_tag[i] <= r_tp_tag[i-1];
      end
    end
  end

  assign req_ready     = !w_req_full;
  assign alu_valid     = r_alu_valid;
  assign alu_op        = r_alu_op;
  assign alu_floating  = r_alu_floating;
  assign alu_form      = r_alu_form;
  assign alu_precision = r_alu_precision;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_c         = r_alu_c;
  assign alu_d         = r_alu_d;
  assign rsp_valid     = !w_rsp_empty;
  assign rsp_y1        = w_rsp_empty ? '0 : w_rsp_head.y1;
  assign rsp_y2        = w_rsp_empty ? '0 : w_rsp_head.y2;
  assign rsp_tag       = w_rsp_empty ? '0 : w_rsp_head.tag;
  assign busy          = !w_req_empty || (|r_tp_vld) || !w_rsp_empty;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: instance A uses a combinational ALU, B a 2-cycle ALU.
`timescale 1ns/1ps
module tb_alu_issue_unit;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  op;
    logic        fl;
    logic        fm;
    logic [1:0]  pr;
    logic [31:0] a, b, c, d;
    logic [3:0]  tag;
  } rq_t;

  typedef struct {
    logic [31:0] y1, y2;
    logic [3:0]  tag;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int iss_a = 0, pop_a = 0, iss_b = 0, pop_b = 0;
  ex_t q_a[$];
  ex_t q_b[$];
  int pop_times[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic        a_req_valid, a_req_ready, a_req_floating, a_req_form;
  logic [2:0]  a_req_op;
  logic [1:0]  a_req_precision;
  logic [31:0] a_req_a, a_req_b, a_req_c, a_req_d;
  logic [3:0]  a_req_tag;
  logic        a_alu_valid, a_alu_floating, a_alu_form;
  logic [2:0]  a_alu_op;
  logic [1:0]  a_alu_precision;
  logic [31:0] a_alu_a, a_alu_b, a_alu_c, a_alu_d, a_alu_y1, a_alu_y2;
  logic        a_rsp_valid, a_rsp_ready, a_busy;
  logic [31:0] a_rsp_y1, a_rsp_y2;
  logic [3:0]  a_rsp_tag;

  logic        b_req_valid, b_req_ready, b_req_floating, b_req_form;
  logic [2:0]  b_req_op;
  logic [1:0]  b_req_precision;
  logic [31:0] b_req_a, b_req_b, b_req_c, b_req_d;
  logic [3:0]  b_req_tag;
  logic        b_alu_valid, b_alu_floating, b_alu_form;
  logic [2:0]  b_alu_op;
  logic [1:0]  b_alu_precision;
  logic [31:0] b_alu_a, b_alu_b, b_alu_c, b_alu_d, b_alu_y1, b_alu_y2;
  logic        b_rsp_valid, b_rsp_ready, b_busy;
  logic [31:0] b_rsp_y1, b_rsp_y2;
  logic [3:0]  b_rsp_tag;

  function automatic logic [63:0] alu_model(input logic [2:0] op, input logic fl, input logic fm,
                                            input logic [1:0] pr, input logic [31:0] a, b, c, d);
    logic [31:0] y1, y2;
    case (op)
      3'd0: y1 = a + b;
      3'd1: y1 = a - b;
      3'd2: y1 = a & b;
      3'd3: y1 = a | b;
      3'd4: y1 = a ^ b;
      3'd5: y1 = a << b[4:0];
      3'd6: y1 = a * b;
      default: y1 = ~a;
    endcase
    y2 = (c ^ d) + {28'd0, fl, fm, pr};
    return {y1, y2};
  endfunction

  assign {a_alu_y1, a_alu_y2} = alu_model(a_alu_op, a_alu_floating, a_alu_form, a_alu_precision,
                                          a_alu_a, a_alu_b, a_alu_c, a_alu_d);

  logic [63:0] b_s1, b_s2;
  always @(posedge clk) begin
    b_s1 <= alu_model(b_alu_op, b_alu_floating, b_alu_form, b_alu_precision,
                      b_alu_a, b_alu_b, b_alu_c, b_alu_d);
    b_s2 <= b_s1;
  end
  assign {b_alu_y1, b_alu_y2} = b_s2;

  alu_issue_unit #(.DEPTH(DEPTH), .ALU_LAT(0), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .req_floating(a_req_floating), .req_form(a_req_form), .req_precision(a_req_precision),
    .req_a(a_req_a), .req_b(a_req_b), .req_c(a_req_c), .req_d(a_req_d), .req_tag(a_req_tag),
    .alu_valid(a_alu_valid), .alu_op(a_alu_op), .alu_floating(a_alu_floating),
    .alu_form(a_alu_form), .alu_precision(a_alu_precision),
    .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_c(a_alu_c), .alu_d(a_alu_d),
    .alu_y1(a_alu_y1), .alu_y2(a_alu_y2),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_y1(a_rsp_y1), .rsp_y2(a_rsp_y2),
    .rsp_tag(a_rsp_tag), .busy(a_busy)
  );

  alu_issue_unit #(.DEPTH(DEPTH), .ALU_LAT(2), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_floating(b_req_floating), .req_form(b_req_form), .req_precision(b_req_precision),
    .req_a(b_req_a), .req_b(b_req_b), .req_c(b_req_c), .req_d(b_req_d), .req_tag(b_req_tag),
    .alu_valid(b_alu_valid), .alu_op(b_alu_op), .alu_floating(b_alu_floating),
    .alu_form(b_alu_form), .alu_precision(b_alu_precision),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_c(b_alu_c), .alu_d(b_alu_d),
    .alu_y1(b_alu_y1), .alu_y2(b_alu_y2),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_y1(b_rsp_y1), .rsp_y2(b_rsp_y2),
    .rsp_tag(b_rsp_tag), .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic rq_t rand_req(input logic [3:0] tag);
    rq_t r;
    r.op  = 3'($urandom_range(0, 7));
    r.fl  = 1'($urandom_range(0, 1));
    r.fm  = 1'($urandom_range(0, 1));
    r.pr  = 2'($urandom_range(0, 3));
    r.a   = $urandom;
    r.b   = $urandom;
    r.c   = $urandom;
    r.d   = $urandom;
    r.tag = tag;
    return r;
  endfunction

  function automatic logic [3:0] next_tag(input bit alt, input logic [3:0] t0, input int i);
    if (alt) return (i % 2 == 1) ? 4'h5 : 4'hA;
    return t0 + 4'(i);
  endfunction

  task automatic apply(input bit sb, input rq_t r, input logic v);
    if (sb) begin
      b_req_valid = v; b_req_op = r.op; b_req_floating = r.fl; b_req_form = r.fm;
      b_req_precision = r.pr; b_req_a = r.a; b_req_b = r.b; b_req_c = r.c; b_req_d = r.d;
      b_req_tag = r.tag;
    end else begin
      a_req_valid = v; a_req_op = r.op; a_req_floating = r.fl; a_req_form = r.fm;
      a_req_precision = r.pr; a_req_a = r.a; a_req_b = r.b; a_req_c = r.c; a_req_d = r.d;
      a_req_tag = r.tag;
    end
  endtask

  // Offers up to n requests, one held until accepted; each acceptance enqueues its expectation.
  task automatic send(input bit sb, input int n, input int budget, input bit alt,
                      input logic [3:0] t0, input bit use_fx, input rq_t fx, output int acc);
    rq_t r;
    int cyc;
    logic [63:0] y;
    acc = 0;
    cyc = 0;
    r = use_fx ? fx : rand_req(next_tag(alt, t0, 0));
    while (acc < n && cyc < budget) begin
      apply(sb, r, 1'b1);
      @(negedge clk);
      if (sb ? b_req_ready : a_req_ready) begin
        y = alu_model(r.op, r.fl, r.fm, r.pr, r.a, r.b, r.c, r.d);
        if (sb) q_b.push_back('{y1: y[63:32], y2: y[31:0], tag: r.tag});
        else    q_a.push_back('{y1: y[63:32], y2: y[31:0], tag: r.tag});
        acc++;
        r = rand_req(next_tag(alt, t0, acc));
      end
      @(posedge clk); #1;
      cyc++;
    end
    apply(sb, r, 1'b0);
  endtask

  task automatic drain(input bit sb, input string nm);
    int cyc;
    cyc = 0;
    while ((((sb ? q_b.size() : q_a.size()) != 0) || (sb ? b_busy : a_busy)) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 300) begin
      failures++;
      $display("FAIL %s_drain actual pending=%0d required=0", nm, sb ? q_b.size() : q_a.size());
    end
  endtask

  task automatic check_reset_a(input string nm);
    chk({nm, "_req_ready"}, 64'(a_req_ready), 64'd1);
    chk({nm, "_alu_valid"}, 64'(a_alu_valid), 64'd0);
    chk({nm, "_alu_ctl"}, 64'({a_alu_op, a_alu_floating, a_alu_form, a_alu_precision}), 64'd0);
    chk({nm, "_alu_ab"}, {a_alu_a, a_alu_b}, 64'd0);
    chk({nm, "_alu_cd"}, {a_alu_c, a_alu_d}, 64'd0);
    chk({nm, "_rsp_valid"}, 64'(a_rsp_valid), 64'd0);
    chk({nm, "_rsp_y"}, {a_rsp_y1, a_rsp_y2}, 64'd0);
    chk({nm, "_rsp_tag"}, 64'(a_rsp_tag), 64'd0);
    chk({nm, "_busy"}, 64'(a_busy), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every response handshake and bounds outstanding ops.
  initial begin
    ex_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        iss_a = 0; pop_a = 0; iss_b = 0; pop_b = 0;
      end else begin
        if (a_alu_valid) begin
          iss_a++;
          checks++;
          if (iss_a - pop_a > DEPTH) begin
            failures++;
            $display("FAIL outstanding_a actual=%0d required<=%0d", iss_a - pop_a, DEPTH);
          end
        end
        if (b_alu_valid) begin
          iss_b++;
          checks++;
          if (iss_b - pop_b > DEPTH) begin
            failures++;
            $display("FAIL outstanding_b actual=%0d required<=%0d", iss_b - pop_b, DEPTH);
          end
        end
        if (a_rsp_valid && a_rsp_ready) begin
          pop_a++;
          pop_times.push_back(edge_cnt);
          if (q_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp_a actual tag=%0h required=no response", a_rsp_tag);
          end else begin
            e = q_a.pop_front();
            chk("rsp_data_a", {a_rsp_y1, a_rsp_y2}, {e.y1, e.y2});
            chk("rsp_tag_a", 64'(a_rsp_tag), 64'(e.tag));
          end
        end
        if (b_rsp_valid && b_rsp_ready) begin
          pop_b++;
          if (q_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp_b actual tag=%0h required=no response", b_rsp_tag);
          end else begin
            e = q_b.pop_front();
            chk("rsp_data_b", {b_rsp_y1, b_rsp_y2}, {e.y1, e.y2});
            chk("rsp_tag_b", 64'(b_rsp_tag), 64'(e.tag));
          end
        end
      end
    end
  end

  initial begin
    rq_t fx;
    int acc, ic0, e0, lat, cyc;
    bit done;
    fx = rand_req(4'd3);
    fx.op = 3'd1; fx.a = 32'd5; fx.b = 32'd7;
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
    apply(1'b0, fx, 1'b0);
    apply(1'b1, fx, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_a("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op, combinational ALU: op=1, A=5, B=7, tag 3.
    send(1'b0, 1, 10, 1'b0, 4'd3, 1'b1, fx, acc);
    e0 = edge_cnt;
    @(negedge clk);
    chk("single_alu_valid_e0", 64'(a_alu_valid), 64'd0);
    @(negedge clk);
    chk("single_alu_valid_e1", 64'(a_alu_valid), 64'd1);
    chk("single_alu_ab", {a_alu_a, a_alu_b}, {32'd5, 32'd7});
    chk("single_rsp_valid_e1", 64'(a_rsp_valid), 64'd0);
    @(negedge clk);
    chk("single_alu_valid_e2", 64'(a_alu_valid), 64'd0);
    chk("single_rsp_valid_e2", 64'(a_rsp_valid), 64'd1);
    chk("single_rsp_tag", 64'(a_rsp_tag), 64'd3);
    chk("single_rsp_y1", 64'(a_rsp_y1), 64'hFFFF_FFFE);
    chk("single_latency", 64'(edge_cnt - e0), 64'd2);
    @(posedge clk); #1;
    a_rsp_ready = 1'b1;
    drain(1'b0, "single");

    // Burst of 8 back-to-back with rsp_ready high.
    pop_times.delete();
    send(1'b0, 8, 40, 1'b0, 4'd0, 1'b0, fx, acc);
    chk("burst_accepted", 64'(acc), 64'd8);
    cyc = 0;
    while (q_a.size() != 0 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("burst_busy_after_last_pop", 64'(a_busy), 64'd0);
    chk("burst_pop_count", 64'(pop_times.size()), 64'd8);
    if (pop_times.size() == 8)
      chk("burst_consecutive", 64'(pop_times[7] - pop_times[0]), 64'd7);
    drain(1'b0, "burst");

    // Backpressure: 10 offered with rsp_ready low.
    a_rsp_ready = 1'b0;
    ic0 = iss_a;
    send(1'b0, 10, 20, 1'b0, 4'd0, 1'b0, fx, acc);
    chk("bp_accepted", 64'(acc), 64'd8);
    chk("bp_issues", 64'(iss_a - ic0), 64'd4);
    chk("bp_req_ready", 64'(a_req_ready), 64'd0);
    a_rsp_ready = 1'b1;
    drain(1'b0, "backpressure");

    // Issue and pop on the same edge with one credit left.
    a_rsp_ready = 1'b0;
    ic0 = iss_a;
    send(1'b0, 3, 10, 1'b0, 4'd4, 1'b0, fx, acc);
    repeat (4) begin @(posedge clk); #1; end
    send(1'b0, 1, 10, 1'b0, 4'd7, 1'b0, fx, acc);
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    @(negedge clk);
    chk("simul_issue_with_pop", 64'(a_alu_valid), 64'd1);
    @(posedge clk); #1;
    send(1'b0, 2, 10, 1'b0, 4'd8, 1'b0, fx, acc);
    repeat (3) begin @(posedge clk); #1; end
    chk("simul_total_issues", 64'(iss_a - ic0), 64'd5);
    a_rsp_ready = 1'b1;
    drain(1'b0, "simul");

    // Random traffic with random backpressure.
    done = 1'b0;
    fork
      begin
        send(1'b0, 40, 600, 1'b0, 4'd0, 1'b0, fx, acc);
        done = 1'b1;
      end
      begin
        while (!done) begin
          a_rsp_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    chk("random_accepted", 64'(acc), 64'd40);
    a_rsp_ready = 1'b1;
    drain(1'b0, "random");

    // Two-cycle ALU: isolated latency, then alternating tags.
    b_rsp_ready = 1'b1;
    send(1'b1, 1, 10, 1'b1, 4'd0, 1'b0, fx, acc);
    e0 = edge_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_rsp_valid) break;
    end
    lat = edge_cnt - e0;
    chk("lat2_latency", 64'(lat), 64'd4);
    @(posedge clk); #1;
    drain(1'b1, "lat2_single");
    send(1'b1, 16, 80, 1'b1, 4'd0, 1'b0, fx, acc);
    chk("lat2_accepted", 64'(acc), 64'd16);
    drain(1'b1, "lat2_alt");

    // Asynchronous reset with ops queued and in flight.
    a_rsp_ready = 1'b0;
    send(1'b0, 7, 20, 1'b0, 4'd0, 1'b0, fx, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_a("midreset");
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset_rsp_valid", 64'(a_rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(1'b0, 3, 10, 1'b0, 4'd9, 1'b0, fx, acc);
    drain(1'b0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
